udp_rx_mux: RTL and testbench

UDP_RX_MUX -- requirements
Module: udp_rx_mux

---
 rtl/udp_rx_pkg.sv | 30 +++
 rtl/udp_csum_acc.sv | 39 +++
 rtl/udp_rx_mux.sv | 187 ++++++++++++++++++
 tb/tb_udp_rx_mux.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/udp_rx_pkg.sv
// udp_rx_pkg: shared definitions for the UDP receive demultiplexer.
//   state_t     - receive FSM encoding
//   udp_hdr_t   - captured header fields used for the accept decision
//   csum_fold   - folds a wide sum into a 16-bit one's-complement value
package udp_rx_pkg;

  localparam int         UDP_HDR_LEN = 8;
  localparam logic [7:0] UDP_PROTO   = 8'd17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD,
    S_DATA,
    S_CHECK,
    S_DROP
  } state_t;

  typedef struct packed {
    logic [15:0] dport;
    logic [15:0] len;
  } udp_hdr_t;

  // Two end-around-carry passes are enough for any input below 2^20.
  function automatic logic [15:0] csum_fold(input logic [19:0] v);
    logic [16:0] t;
    t = {1'b0, v[15:0]} + {13'd0, v[19:16]};
    return t[15:0] + {15'd0, t[16]};
  endfunction

endpackage

// File: rtl/udp_csum_acc.sv
// udp_csum_acc: byte-wise 16-bit one's-complement accumulator.
//   clk, rst  - clock, async active-high reset
//   clr       - restart from init (the byte on data is still added when en)
//   en        - add data this cycle
//   hi        - data is the high byte of its 16-bit word
//   dbl       - add the byte twice (field that also appears in the pseudo-header)
//   data      - byte to accumulate
//   init      - folded pseudo-header seed
//   sum       - running folded sum
module udp_csum_acc
  import udp_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        hi,
  input  logic        dbl,
  input  logic [7:0]  data,
  input  logic [15:0] init,
  output logic [15:0] sum
);

  logic [15:0] word, base;
  logic [17:0] raw;

  always_comb begin
    word = hi ? {data, 8'h00} : {8'h00, data};
    base = clr ? init : sum;
    raw  = {2'b00, base} + {2'b00, word} + (dbl ? {2'b00, word} : 18'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      sum <= '0;
    else if (en)  sum <= csum_fold({2'b00, raw});
    else if (clr) sum <= init;
  end

endmodule

// File: rtl/udp_rx_mux.sv
// udp_rx_mux: parses a UDP segment byte stream, steers the payload of packets
// addressed to PORT_BASE..PORT_BASE+NUM_CH-1 onto a channel-tagged output and
// drops everything else.
//   clk, rst                     - clock, async active-high reset
//   rx_data/rx_valid/rx_sop      - incoming UDP segment, header first
//   ip_checksum_error,
//   ip_addr_check_error          - IP-layer error flags
//   ip_src_addr, ip_dst_addr     - pseudo-header addresses
//   pld_data/valid/sof/eof       - payload stream, 1 cycle after acceptance
//   pld_chan, pld_len            - channel and payload length of current packet
//   pkt_done, pkt_good           - end-of-packet pulse and verdict
//   drop_cnt                     - saturating dropped-packet count
// Optional feature: define UDP_RX_CSUM_EN to verify the UDP checksum.
module udp_rx_mux
  import udp_rx_pkg::*;
#(
  parameter logic [15:0] PORT_BASE = 16'hF000,
  parameter int          NUM_CH    = 4,
  parameter int          MAX_LEN   = 1472,
  localparam int         CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          rx_sop,
  input  logic          ip_checksum_error,
  input  logic          ip_addr_check_error,
  input  logic [31:0]   ip_src_addr,
  input  logic [31:0]   ip_dst_addr,
  output logic [7:0]    pld_data,
  output logic          pld_valid,
  output logic          pld_sof,
  output logic          pld_eof,
  output logic [CW-1:0] pld_chan,
  output logic [15:0]   pld_len,
  output logic          pkt_done,
  output logic          pkt_good,
  output logic [15:0]   drop_cnt
);

  state_t      state;
  udp_hdr_t    hdr;
  logic [2:0]  hdr_idx;
  logic [15:0] pay_cnt;
  logic        err;

  logic        ip_err, start, len_short, len_long, port_ok, hdr_bad, verdict;
  logic [15:0] pay_len, drop_inc;
  logic [16:0] port_off;

  always_comb begin
    ip_err    = ip_checksum_error | ip_addr_check_error;
    start     = rx_valid & rx_sop;
    len_short = hdr.len < 16'(UDP_HDR_LEN);
    // Only meaningful once len_short is known false.
    pay_len   = hdr.len - 16'(UDP_HDR_LEN);
    len_long  = !len_short && ({1'b0, pay_len} > 17'(MAX_LEN));
    // 17-bit difference: a port below PORT_BASE wraps and sets bit 16.
    port_off  = {1'b0, hdr.dport} - {1'b0, PORT_BASE};
    port_ok   = !port_off[16] && (port_off < 17'(NUM_CH));
    hdr_bad   = len_short | len_long | !port_ok | err | ip_err;
    drop_inc  = (drop_cnt != 16'hFFFF) ? drop_cnt + 16'd1 : drop_cnt;
  end

`ifdef UDP_RX_CSUM_EN
  logic [15:0] csum, acc_sum, acc_init;
  logic        acc_en, acc_hi, acc_dbl;

  always_comb begin
    acc_init = csum_fold(20'(ip_src_addr[31:16]) + 20'(ip_src_addr[15:0]) +
                         20'(ip_dst_addr[31:16]) + 20'(ip_dst_addr[15:0]) +
                         20'(UDP_PROTO));
    acc_en   = rx_valid & (rx_sop | (state == S_HEAD) | (state == S_DATA));
    // Header byte k sits at segment offset k, payload byte j at 8+j.
    acc_hi   = rx_sop ? 1'b1 : (state == S_HEAD) ? !hdr_idx[0] : !pay_cnt[0];
    // The length field is counted once in the header and once in the pseudo-header.
    acc_dbl  = !rx_sop && (state == S_HEAD) && ((hdr_idx == 3'd4) || (hdr_idx == 3'd5));
    verdict  = !err && ((acc_sum == 16'hFFFF) || (csum == 16'h0000));
  end

  udp_csum_acc u_csum (
    .clk  (clk),
    .rst  (rst),
    .clr  (start),
    .en   (acc_en),
    .hi   (acc_hi),
    .dbl  (acc_dbl),
    .data (rx_data),
    .init (acc_init),
    .sum  (acc_sum)
  );
`else
  logic unused_ip;
  assign unused_ip = ^{ip_src_addr, ip_dst_addr};
  assign verdict   = !err;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      hdr       <= '0;
      hdr_idx   <= '0;
      pay_cnt   <= '0;
      err       <= 1'b0;
      pld_data  <= '0;
      pld_valid <= 1'b0;
      pld_sof   <= 1'b0;
      pld_eof   <= 1'b0;
      pld_chan  <= '0;
      pld_len   <= '0;
      pkt_done  <= 1'b0;
      pkt_good  <= 1'b0;
      drop_cnt  <= '0;
`ifdef UDP_RX_CSUM_EN
      csum      <= '0;
`endif
    end else begin
      pld_valid <= 1'b0;
      pld_sof   <= 1'b0;
      pld_eof   <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_good  <= 1'b0;

      if ((state == S_HEAD) || (state == S_DATA)) err <= err | ip_err;

      // CHECK reports even when a new packet starts in the same cycle.
      if (state == S_CHECK) begin
        pkt_done <= 1'b1;
        pkt_good <= verdict;
      end

      if (start) begin
        // A new header always wins; an interrupted payload counts as a drop.
        if (state == S_DATA) begin
          pkt_done <= 1'b1;
          drop_cnt <= drop_inc;
        end
        state   <= S_HEAD;
        hdr_idx <= 3'd1;
        err     <= ip_err;
      end else begin
        case (state)
          S_HEAD: if (rx_valid) begin
            hdr_idx <= hdr_idx + 3'd1;
            case (hdr_idx)
              3'd2: hdr.dport[15:8] <= rx_data;
              3'd3: hdr.dport[7:0]  <= rx_data;
              3'd4: hdr.len[15:8]   <= rx_data;
              3'd5: hdr.len[7:0]    <= rx_data;
`ifdef UDP_RX_CSUM_EN
              3'd6: csum[15:8]      <= rx_data;
              3'd7: csum[7:0]       <= rx_data;
`endif
              default: ;
            endcase
            if (hdr_idx == 3'd7) begin
              if (hdr_bad) begin
                state    <= S_DROP;
                pkt_done <= 1'b1;
                drop_cnt <= drop_inc;
              end else begin
                pld_chan <= port_off[CW-1:0];
                pld_len  <= pay_len;
                pay_cnt  <= '0;
                state    <= (pay_len == 16'd0) ? S_CHECK : S_DATA;
              end
            end
          end
          S_DATA: if (rx_valid) begin
            pld_valid <= 1'b1;
            pld_data  <= rx_data;
            pld_sof   <= (pay_cnt == 16'd0);
            pay_cnt   <= pay_cnt + 16'd1;
            if (pay_cnt == pld_len - 16'd1) begin
              pld_eof <= 1'b1;
              state   <= S_CHECK;
            end
          end
          S_CHECK: state <= S_IDLE;
          default: ;  // IDLE and DROP wait for the next sop
        endcase
      end
    end
  end

endmodule

// File: tb/tb_udp_rx_mux.sv
module tb_udp_rx_mux;
  import udp_rx_pkg::*;

`ifdef UDP_RX_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0, rx_sop = 1'b0;
  logic        ip_checksum_error = 1'b0, ip_addr_check_error = 1'b0;
  logic [31:0] ip_src_addr = 32'hC0A8_0001, ip_dst_addr = 32'hC0A8_0002;
  logic [7:0]  pld_data;
  logic        pld_valid, pld_sof, pld_eof, pkt_done, pkt_good;
  logic [1:0]  pld_chan;
  logic [15:0] pld_len, drop_cnt;

  udp_rx_mux #(.PORT_BASE(16'hF000), .NUM_CH(4), .MAX_LEN(1472)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop),
    .ip_checksum_error(ip_checksum_error), .ip_addr_check_error(ip_addr_check_error),
    .ip_src_addr(ip_src_addr), .ip_dst_addr(ip_dst_addr),
    .pld_data(pld_data), .pld_valid(pld_valid), .pld_sof(pld_sof), .pld_eof(pld_eof),
    .pld_chan(pld_chan), .pld_len(pld_len), .pkt_done(pkt_done), .pkt_good(pkt_good),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Output monitor
  logic [7:0] q[$];
  bit         goods[$];
  int sof_cnt, eof_cnt, sof_pos, eof_pos, done_cnt, chan_s, len_s, chan_bad;

  task automatic mon_clear();
    q.delete(); goods.delete();
    sof_cnt = 0; eof_cnt = 0; sof_pos = -1; eof_pos = -1;
    done_cnt = 0; chan_s = -1; len_s = -1; chan_bad = 0;
  endtask

  always @(negedge clk) begin
    if (pld_valid) begin
      if (pld_sof) begin
        sof_cnt++; sof_pos = q.size(); chan_s = int'(pld_chan); len_s = int'(pld_len);
      end else if (int'(pld_chan) != chan_s) chan_bad++;
      if (pld_eof) begin eof_cnt++; eof_pos = q.size(); end
      q.push_back(pld_data);
    end
    if (pkt_done) begin done_cnt++; goods.push_back(pkt_good); end
  end

  function automatic logic [15:0] udp_csum(input logic [15:0] dport, input logic [15:0] len);
    logic [31:0] s;
    logic [15:0] c;
    logic [31:0] src, dst;
    int pl;
    src = ip_src_addr; dst = ip_dst_addr;
    s = 32'(src[31:16]) + 32'(src[15:0]) + 32'(dst[31:16]) + 32'(dst[15:0]) +
        32'd17 + 32'(len) + 32'h1234 + 32'(dport) + 32'(len);
    pl = int'(len) - 8;
    for (int j = 0; j < pl; j++)
      s += (j % 2 == 0) ? 32'({8'(j + 1), 8'h00}) : 32'(8'(j + 1));
    while (s[31:16] != 0) s = 32'(s[15:0]) + 32'(s[31:16]);
    c = ~s[15:0];
    if (c == 16'h0000) c = 16'hFFFF;
    return c;
  endfunction

  // mode: 0 correct checksum, 1 flipped LSB, 2 zero; err: 1 in header, 2 in payload
  task automatic send_pkt(input logic [15:0] dport, input logic [15:0] len,
                          input int n, input int extra, input int mode,
                          input int gap, input int err);
    logic [15:0] c;
    logic [7:0]  b[$];
    c = udp_csum(dport, len);
    if (mode == 1) c = c ^ 16'h0001;
    if (mode == 2) c = 16'h0000;
    b = '{8'h12, 8'h34, dport[15:8], dport[7:0], len[15:8], len[7:0], c[15:8], c[7:0]};
    for (int j = 0; j < n; j++) b.push_back(8'(j + 1));
    for (int j = 0; j < extra; j++) b.push_back(8'hEE);
    for (int i = 0; i < b.size(); i++) begin
      @(negedge clk);
      rx_valid = 1'b1; rx_sop = (i == 0); rx_data = b[i];
      ip_checksum_error   = (err == 1) && (i == 3);
      ip_addr_check_error = (err == 2) && (i == 11);
      if (gap != 0)
        repeat ((i % 3) + 1) begin
          @(negedge clk);
          rx_valid = 1'b0; rx_sop = 1'b0;
          ip_checksum_error = 1'b0; ip_addr_check_error = 1'b0;
        end
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      rx_valid = 1'b0; rx_sop = 1'b0;
      ip_checksum_error = 1'b0; ip_addr_check_error = 1'b0;
    end
  endtask

  function automatic int data_bad(input int from, input int cnt);
    int bad = 0;
    for (int j = 0; j < cnt; j++)
      if (from + j >= q.size() || q[from + j] != 8'(j + 1)) bad++;
    return bad;
  endfunction

  typedef struct {
    logic [15:0] dport, len;
    int n, extra, mode, gap, err;
    bit exp_drop, exp_good;
    int exp_n, exp_chan;
  } vec_t;

  vec_t vt[15];

  initial begin
    int d0;
    vt[0]  = '{16'hF002, 16'd18,   10,   0, 0, 0, 0, 1'b0, 1'b1, 10,   2};
    vt[1]  = '{16'hF004, 16'd18,   10,   0, 0, 0, 0, 1'b1, 1'b0, 0,    0};
    vt[2]  = '{16'hF000, 16'd1481, 4,    0, 0, 0, 0, 1'b1, 1'b0, 0,    0};
    vt[3]  = '{16'hF001, 16'd8,    0,    0, 0, 0, 0, 1'b0, 1'b1, 0,    0};
    vt[4]  = '{16'hF000, 16'd5,    4,    0, 0, 0, 0, 1'b1, 1'b0, 0,    0};
    vt[5]  = '{16'hF000, 16'd11,   3,    0, 0, 0, 0, 1'b0, 1'b1, 3,    0};
    vt[6]  = '{16'hF002, 16'd18,   10,   0, 0, 1, 0, 1'b0, 1'b1, 10,   2};
    vt[7]  = '{16'hF001, 16'd18,   10,   0, 1, 0, 0, 1'b0, !CSUM, 10,  1};
    vt[8]  = '{16'hF001, 16'd18,   10,   0, 2, 0, 0, 1'b0, 1'b1, 10,   1};
    vt[9]  = '{16'hF002, 16'd18,   10,   0, 0, 0, 1, 1'b1, 1'b0, 0,    0};
    vt[10] = '{16'hF002, 16'd18,   10,   0, 0, 0, 2, 1'b0, 1'b0, 10,   2};
    vt[11] = '{16'hEFFF, 16'd18,   10,   0, 0, 0, 0, 1'b1, 1'b0, 0,    0};
    vt[12] = '{16'hF001, 16'd1480, 1472, 0, 0, 0, 0, 1'b0, 1'b1, 1472, 1};
    vt[13] = '{16'hF001, 16'd12,   4,    3, 0, 0, 0, 1'b0, 1'b1, 4,    1};
    vt[14] = '{16'hF003, 16'd18,   10,   0, 0, 0, 0, 1'b0, 1'b1, 10,   3};

    mon_clear();
    // Reset state
    repeat (2) @(negedge clk);
    check("rst pld_valid", pld_valid, 0);
    check("rst pld_data", pld_data, 0);
    check("rst pld_len", pld_len, 0);
    check("rst pld_chan", pld_chan, 0);
    check("rst pkt_done", pkt_done, 0);
    check("rst drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    idle(2);

    foreach (vt[k]) begin
      d0 = int'(drop_cnt);
      mon_clear();
      send_pkt(vt[k].dport, vt[k].len, vt[k].n, vt[k].extra, vt[k].mode, vt[k].gap, vt[k].err);
      idle(8);
      check($sformatf("v%0d done", k), done_cnt, 1);
      check($sformatf("v%0d good", k), goods.size() > 0 ? int'(goods[0]) : -1, int'(vt[k].exp_good));
      check($sformatf("v%0d nbytes", k), q.size(), vt[k].exp_n);
      check($sformatf("v%0d drop_cnt", k), drop_cnt, d0 + int'(vt[k].exp_drop));
      check($sformatf("v%0d sof_cnt", k), sof_cnt, vt[k].exp_n > 0 ? 1 : 0);
      check($sformatf("v%0d eof_cnt", k), eof_cnt, vt[k].exp_n > 0 ? 1 : 0);
      if (vt[k].exp_n > 0) begin
        check($sformatf("v%0d data", k), data_bad(0, vt[k].exp_n), 0);
        check($sformatf("v%0d sof_pos", k), sof_pos, 0);
        check($sformatf("v%0d eof_pos", k), eof_pos, vt[k].exp_n - 1);
        check($sformatf("v%0d chan", k), chan_s, vt[k].exp_chan);
        check($sformatf("v%0d len", k), len_s, vt[k].exp_n);
        check($sformatf("v%0d chan_stable", k), chan_bad, 0);
      end
    end

    // Abort: sop arrives in place of payload byte 5 of a 20-byte payload
    d0 = int'(drop_cnt);
    mon_clear();
    send_pkt(16'hF001, 16'd28, 4, 0, 0, 0, 0);
    send_pkt(16'hF002, 16'd18, 10, 0, 0, 0, 0);
    idle(8);
    check("abort done", done_cnt, 2);
    check("abort good0", goods.size() > 0 ? int'(goods[0]) : -1, 0);
    check("abort good1", goods.size() > 1 ? int'(goods[1]) : -1, 1);
    check("abort nbytes", q.size(), 14);
    check("abort data0", data_bad(0, 4), 0);
    check("abort data1", data_bad(4, 10), 0);
    check("abort sof_cnt", sof_cnt, 2);
    check("abort eof_cnt", eof_cnt, 1);
    check("abort eof_pos", eof_pos, 13);
    check("abort chan", chan_s, 2);
    check("abort drop_cnt", drop_cnt, d0 + 1);

    // Reset in the middle of a payload
    mon_clear();
    send_pkt(16'hF001, 16'd18, 3, 0, 0, 0, 0);
    @(negedge clk);
    rx_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("mrst pld_valid", pld_valid, 0);
    check("mrst pld_len", pld_len, 0);
    check("mrst drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    idle(6);
    check("mrst done", done_cnt, 0);
    check("mrst eof", eof_cnt, 0);
    check("mrst nbytes", q.size(), 3);
    mon_clear();
    send_pkt(16'hF000, 16'd12, 4, 0, 0, 0, 0);
    idle(8);
    check("post rst good", goods.size() > 0 ? int'(goods[0]) : -1, 1);
    check("post rst nbytes", q.size(), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
